// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
package uart_pkg;

    // Frame-tracking states; 3-bit encoding shared by both link ends.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BIT   = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4,
        WAIT_HIGH  = 3'd5
    } state_e;

    // Default baud divider: clock cycles per serial bit.
    localparam int unsigned CYCLE_PER_BIT_DEFAULT = 115;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture; both stages reset to the line's idle level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/rx_uart.sv
// UART 8N1 receiver: synchronises the line, finds the start bit, samples each bit at
// mid-bit and emits the byte with a one-cycle valid pulse, flagging framing errors.
// Optional even parity is compiled in with the RX_UART_PARITY_EN macro.
module rx_uart
    import uart_pkg::*;
#(
    parameter int unsigned CYCLE_PER_BIT = CYCLE_PER_BIT_DEFAULT
) (
    input  logic       clk_rx,
    input  logic       rst_rx,
    input  logic       enable_rx,
    input  logic       in_serial_rx,
    output logic [7:0] out_byte_rx,
    output logic       out_valid_rx,
    output logic       out_frame_err_rx,
    output logic       out_parity_err_rx
);

    localparam logic [15:0] CntLast = 16'(CYCLE_PER_BIT - 1);
    localparam logic [15:0] CntHalf = 16'(CYCLE_PER_BIT / 2);

    logic line_s;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
`ifdef RX_UART_PARITY_EN
    logic        par_bad_q, par_bad_d;
    logic        perr_q, perr_d;
`endif

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk_i (clk_rx),
        .rst_ni(rst_rx),
        .d_i   (in_serial_rx),
        .q_o   (line_s)
    );

    // Next-state and output-pulse logic for the frame FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef RX_UART_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        if (enable_rx != ENABLE) begin
            // Turnaround: drop any partial frame silently.
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    idx_d = '0;
`ifdef RX_UART_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                    if (!line_s) state_d = START_BIT;
                end
                START_BIT: begin
                    if (cnt_q == CntHalf) begin
                        cnt_d   = '0;
                        // A line already back high at mid-start is a glitch.
                        state_d = line_s ? IDLE : DATA_BIT;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                DATA_BIT: begin
                    if (cnt_q == CntLast) begin
                        cnt_d          = '0;
                        shift_d[idx_q] = line_s;
                        idx_d          = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
`ifdef RX_UART_PARITY_EN
                            state_d = PARITY_BIT;
`else
                            state_d = STOP_BIT;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
`ifdef RX_UART_PARITY_EN
                PARITY_BIT: begin
                    if (cnt_q == CntLast) begin
                        cnt_d     = '0;
                        par_bad_d = line_s ^ (^shift_q);
                        state_d   = STOP_BIT;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
`endif
                STOP_BIT: begin
                    if (cnt_q == CntLast) begin
                        cnt_d = '0;
                        if (line_s) begin
                            // Re-arm immediately; no wait for the end of the stop bit.
                            byte_d  = shift_q;
                            valid_d = 1'b1;
`ifdef RX_UART_PARITY_EN
                            perr_d  = par_bad_q;
`endif
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_HIGH;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                WAIT_HIGH: begin
                    // Hold off until a break ends so it is not read as 0x00 frames.
                    if (line_s) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk_rx or negedge rst_rx) begin
        if (!rst_rx) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef RX_UART_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef RX_UART_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign out_byte_rx      = byte_q;
    assign out_valid_rx     = valid_q;
    assign out_frame_err_rx = ferr_q;
`ifdef RX_UART_PARITY_EN
    assign out_parity_err_rx = perr_q;
`else
    assign out_parity_err_rx = 1'b0;
`endif

endmodule

// File: tb/tb_rx_uart.sv
// Directed bench for rx_uart: table of frames plus hand-written corner sequences.
module tb_rx_uart;

    localparam int unsigned CPB  = 16;
    localparam int unsigned HALF = CPB / 2;
`ifdef RX_UART_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    // Cycle (edge count after e0) whose following cycle carries the valid pulse.
    localparam int LAT = int'(HALF + 3 + (NBITS - 1) * CPB);

    logic       clk_rx = 1'b0;
    logic       rst_rx = 1'b0;
    logic       enable_rx = 1'b1;
    logic       in_serial_rx = 1'b1;
    logic [7:0] out_byte_rx;
    logic       out_valid_rx;
    logic       out_frame_err_rx;
    logic       out_parity_err_rx;

    rx_uart #(
        .CYCLE_PER_BIT(CPB)
    ) dut (
        .clk_rx           (clk_rx),
        .rst_rx           (rst_rx),
        .enable_rx        (enable_rx),
        .in_serial_rx     (in_serial_rx),
        .out_byte_rx      (out_byte_rx),
        .out_valid_rx     (out_valid_rx),
        .out_frame_err_rx (out_frame_err_rx),
        .out_parity_err_rx(out_parity_err_rx)
    );

    always #5 clk_rx = ~clk_rx;

    int cyc = 0;
    always @(posedge clk_rx) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    int         n_valid = 0, n_ferr = 0, n_perr = 0, n_wide = 0, n_perr_alone = 0;
    logic       prev_v = 1'b0;
    logic [7:0] got_q[$];
    int         got_cyc_q[$];
    always @(negedge clk_rx) begin
        if (out_valid_rx) begin
            n_valid <= n_valid + 1;
            got_q.push_back(out_byte_rx);
            got_cyc_q.push_back(cyc);
            if (prev_v) n_wide <= n_wide + 1;
        end
        if (out_frame_err_rx) n_ferr <= n_ferr + 1;
        if (out_parity_err_rx) begin
            n_perr <= n_perr + 1;
            if (!out_valid_rx) n_perr_alone <= n_perr_alone + 1;
        end
        prev_v <= out_valid_rx;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_rx);
        #1;
    endtask

    // Drive one frame; e0 is the edge where the first sync flop captures the start bit.
    task automatic send_frame(input logic [7:0] data, input logic par_flip,
                              input logic stop_val, input int stop_len, output int e0);
        in_serial_rx = 1'b0;
        e0 = cyc + 1;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            in_serial_rx = data[i];
            repeat (CPB) tick();
        end
`ifdef RX_UART_PARITY_EN
        in_serial_rx = (^data) ^ par_flip;
        repeat (CPB) tick();
`else
        if (par_flip) in_serial_rx = 1'b1;
`endif
        in_serial_rx = stop_val;
        repeat (stop_len) tick();
        in_serial_rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_val;
        int         stop_len;
        logic [7:0] exp_byte;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e0, e1, v0, f0, p0;

        vecs[0] = '{8'hA5, 1'b1, CPB, 8'hA5, 1, 0};
        vecs[1] = '{8'h3C, 1'b0, 40,  8'hA5, 0, 1};
        vecs[2] = '{8'h81, 1'b1, CPB, 8'h81, 1, 0};
        vecs[3] = '{8'h00, 1'b1, CPB, 8'h00, 1, 0};
        vecs[4] = '{8'hFF, 1'b1, CPB, 8'hFF, 1, 0};
        vecs[5] = '{8'h6E, 1'b1, CPB, 8'h6E, 1, 0};

        // Reset state
        repeat (3) tick();
        check("rst_byte", int'(out_byte_rx), 0);
        check("rst_valid", int'(out_valid_rx), 0);
        check("rst_ferr", int'(out_frame_err_rx), 0);
        check("rst_perr", int'(out_parity_err_rx), 0);
        rst_rx = 1'b1;
        repeat (4) tick();

        // Table-driven frames
        foreach (vecs[k]) begin
            v0 = n_valid; f0 = n_ferr; p0 = n_perr;
            got_q.delete(); got_cyc_q.delete();
            send_frame(vecs[k].data, 1'b0, vecs[k].stop_val, vecs[k].stop_len, e0);
            repeat (2 * CPB) tick();
            check($sformatf("vec%0d_byte", k), int'(out_byte_rx), int'(vecs[k].exp_byte));
            check($sformatf("vec%0d_valid", k), n_valid - v0, vecs[k].exp_valid);
            check($sformatf("vec%0d_ferr", k), n_ferr - f0, vecs[k].exp_ferr);
            check($sformatf("vec%0d_perr", k), n_perr - p0, 0);
            if (vecs[k].exp_valid == 1 && got_cyc_q.size() == 1)
                check($sformatf("vec%0d_latency", k), got_cyc_q[0] - e0, LAT);
        end

        // Back-to-back frames with no idle gap
        v0 = n_valid;
        got_q.delete(); got_cyc_q.delete();
        send_frame(8'h00, 1'b0, 1'b1, CPB, e0);
        send_frame(8'hFF, 1'b0, 1'b1, CPB, e1);
        repeat (2 * CPB) tick();
        check("b2b_count", n_valid - v0, 2);
        if (got_q.size() == 2) begin
            check("b2b_byte0", int'(got_q[0]), 8'h00);
            check("b2b_byte1", int'(got_q[1]), 8'hFF);
            check("b2b_spacing", got_cyc_q[1] - got_cyc_q[0], int'(CPB * NBITS));
            check("b2b_lat0", got_cyc_q[0] - e0, LAT);
        end

        // Short low glitch on idle line
        v0 = n_valid; f0 = n_ferr;
        in_serial_rx = 1'b0;
        repeat (5) tick();
        in_serial_rx = 1'b1;
        repeat (3 * CPB) tick();
        check("glitch_valid", n_valid - v0, 0);
        check("glitch_ferr", n_ferr - f0, 0);
        check("glitch_byte", int'(out_byte_rx), 8'hFF);
        check("glitch_idle", int'(dut.state_q), 0);
        send_frame(8'h42, 1'b0, 1'b1, CPB, e0);
        repeat (2 * CPB) tick();
        check("glitch_next_byte", int'(out_byte_rx), 8'h42);
        check("glitch_next_valid", n_valid - v0, 1);

        // enable_rx dropped mid-frame
        v0 = n_valid; f0 = n_ferr;
        in_serial_rx = 1'b0;
        repeat (CPB) tick();
        in_serial_rx = 1'b1;
        repeat (2 * CPB + 5) tick();
        enable_rx = 1'b0;
        in_serial_rx = 1'b1;
        repeat (3) tick();
        enable_rx = 1'b1;
        repeat (12 * CPB) tick();
        check("en_abort_valid", n_valid - v0, 0);
        check("en_abort_ferr", n_ferr - f0, 0);
        check("en_abort_byte", int'(out_byte_rx), 8'h42);
        send_frame(8'h5A, 1'b0, 1'b1, CPB, e0);
        repeat (2 * CPB) tick();
        check("en_next_byte", int'(out_byte_rx), 8'h5A);
        check("en_next_valid", n_valid - v0, 1);

        // Asynchronous reset mid-frame
        send_frame(8'h99, 1'b0, 1'b1, CPB, e0);
        repeat (2 * CPB) tick();
        v0 = n_valid; f0 = n_ferr;
        in_serial_rx = 1'b0;
        repeat (CPB) tick();
        in_serial_rx = 1'b1;
        repeat (3 * CPB) tick();
        rst_rx = 1'b0;
        #1;
        check("mid_rst_byte", int'(out_byte_rx), 0);
        check("mid_rst_valid", int'(out_valid_rx), 0);
        check("mid_rst_ferr", int'(out_frame_err_rx), 0);
        tick();
        tick();
        rst_rx = 1'b1;
        repeat (12 * CPB) tick();
        check("rst_abort_valid", n_valid - v0, 0);
        check("rst_abort_ferr", n_ferr - f0, 0);
        send_frame(8'h5A, 1'b0, 1'b1, CPB, e0);
        repeat (2 * CPB) tick();
        check("rst_next_byte", int'(out_byte_rx), 8'h5A);
        check("rst_next_valid", n_valid - v0, 1);

`ifdef RX_UART_PARITY_EN
        // Wrong parity: byte still delivered, error pulse alongside valid
        v0 = n_valid; p0 = n_perr;
        send_frame(8'h07, 1'b1, 1'b1, CPB, e0);
        repeat (2 * CPB) tick();
        check("par_valid", n_valid - v0, 1);
        check("par_perr", n_perr - p0, 1);
        check("par_byte", int'(out_byte_rx), 8'h07);
`endif

        check("valid_width", n_wide, 0);
        check("perr_without_valid", n_perr_alone, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_uart.md
# rx_uart

UART serial receiver: the receive end of the 8N1 link driven by the team's UART transmitter, used in the half-duplex BLE communication path. It synchronises the incoming serial line, detects the start bit, samples each bit at mid-bit, and presents the reassembled byte with a one-cycle valid pulse. It also flags framing errors. It uses the same CYCLE_PER_BIT timing as the transmitter, so both ends run at the same baud rate from the same clock.

## Interface
- CYCLE_PER_BIT, 115: clock cycles per serial bit; must be ≥ 4.
- HALF_BIT, CYCLE_PER_BIT/2 (integer division): cycle offset from start-bit detection to its mid-bit check.
- clk_rx  in  1  single clock, rising edge.
- rst_rx  in  1  reset; asynchronous, active-low.
- enable_rx  in  1  1 = receiver active; 0 = hold in IDLE (half-duplex turnaround).
- in_serial_rx  in  1  asynchronous serial line; idle high; LSB first.
- out_byte_rx  out  8  last correctly received byte; held until the next good frame.
- out_valid_rx  out  1  one-cycle pulse when out_byte_rx updates.
- out_frame_err_rx  out  1  one-cycle pulse when the stop bit is sampled low.
- out_parity_err_rx  out  1  one-cycle pulse on parity mismatch; tied 0 when parity is compiled out.

## Operation
- Input synchroniser: two flops on in_serial_rx, both reset to 1. The FSM sees only the second flop (line_s).
- States: IDLE, START_BIT, DATA_BIT, PARITY_BIT, STOP_BIT, WAIT_HIGH (3-bit encoding).
- IDLE: clk_count=0, data_index=0.
  - If enable_rx=1 and line_s=0, go to START_BIT.
- START_BIT: count up to HALF_BIT.
  - At HALF_BIT, if line_s=0, go to DATA_BIT with count=0.
  - If line_s=1 at that point, treat it as a glitch: return to IDLE with no output activity.
- DATA_BIT: sample line_s when clk_count=CYCLE_PER_BIT-1 into shift bit [data_index], then set count=0.
  - After index 7, go to PARITY_BIT if compiled in, else STOP_BIT.
  - data_index is 3 bits and wraps naturally. The exit condition is the sample taken at index 7, never a compare against 8.
- STOP_BIT: sample at CYCLE_PER_BIT-1.
  - Sample 1: load out_byte_rx, pulse out_valid_rx, go to IDLE. No wait for the full stop bit, which gives half-bit clock-skew tolerance.
  - Sample 0: pulse out_frame_err_rx, leave out_byte_rx unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until line_s=1, then go to IDLE. This prevents a break condition from being read as repeated 0x00 frames.
- enable_rx=0 in any state: next state IDLE, counters cleared, no pulses. A partial frame is discarded.
- The error and valid pulses are mutually exclusive within a frame.
- Parity error and valid can both fire for the same frame: the byte is still delivered, and software decides what to do with it.

## Timing
- Reset values:
  - out_byte_rx=8'h00; out_valid_rx, out_frame_err_rx, out_parity_err_rx = 0.
  - State IDLE; clk_count=0; data_index=0; synchroniser flops=1.
- Latency: let e0 be the clock edge whose first synchroniser flop first captures the start bit's 0.
  - out_valid_rx is high for exactly the one cycle following edge e0 + HALF_BIT + 3 + 9·CYCLE_PER_BIT.
  - Add CYCLE_PER_BIT when parity is enabled.
- Bit i (0..7) is sampled at start-detect + HALF_BIT + 1 + (i+1)·CYCLE_PER_BIT cycles.
- Back-to-back frames with no idle gap are accepted: IDLE re-arms in the cycle after the stop sample.
- clk_count is 16 bits, so CYCLE_PER_BIT ≤ 65535.
- Reset assertion mid-frame returns everything to reset values immediately (asynchronous). No pulse is produced for the aborted frame.

## Configuration
- RX_UART_PARITY_EN defined:
  - PARITY_BIT state is present; one even-parity bit is expected after bit 7.
  - Parity is sampled at mid-bit. A mismatch pulses out_parity_err_rx in the same cycle as out_valid_rx.
- RX_UART_PARITY_EN undefined:
  - PARITY_BIT is unreachable; DATA_BIT goes directly to STOP_BIT.
  - out_parity_err_rx is constant 0.

## Structure
- Shared package uart_pkg holds:
  - the state typedef (IDLE, START_BIT, DATA_BIT, PARITY_BIT, STOP_BIT, WAIT_HIGH);
  - the default CYCLE_PER_BIT constant;
  - the ENABLE/DISABLE constants.
- The transmitter imports the same package.
- One sub-module, sync_2ff: a two-flop synchroniser with an asynchronous active-low reset and a parameterised reset value, instantiated with reset value 1.
- The remainder is a single registered FSM plus a next-state combinational block.

## Test plan
- CYCLE_PER_BIT=16, enable_rx=1, send byte 8'hA5 8N1 → out_byte_rx=8'hA5 with a 1-cycle out_valid_rx at e0+8+3+144; no error pulses.
- Frames 8'h00 then 8'hFF sent back-to-back with no gap → two valid pulses 16·10 cycles apart, carrying 8'h00 and 8'hFF.
- 5-cycle low glitch on the idle line → no pulses; FSM back in IDLE; out_byte_rx unchanged.
- Byte 8'h3C with stop bit forced 0 for 40 cycles → out_frame_err_rx pulse only; out_byte_rx keeps its previous value; the next good frame 8'h81 is received correctly.
- rst_rx low for 2 cycles mid-DATA_BIT, then byte 8'h5A → all outputs at reset values during reset; no pulse for the aborted frame; 8'h5A received correctly. Repeat with enable_rx dropped mid-frame → same result.
- With RX_UART_PARITY_EN, send 8'h07 with parity bit 0 (wrong) → out_valid_rx and out_parity_err_rx pulse in the same cycle; out_byte_rx=8'h07.
